// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph constants, LED bit positions and scan FSM encoding.
// Used by seg7_decode, seg7_scan_ctrl and other display blocks.
package seg7_pkg;

    // Glyphs are {A,B,C,D,E,F,G}; on the LED bus they occupy bits [7:1]
    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Digit idx is a leading zero when it and every digit to its left are 0; digit0 never is
    function automatic logic lz_blank(input logic [15:0] digits, input logic [1:0] idx);
        case (idx)
            2'd3:    return digits[15:12] == 4'h0;
            2'd2:    return digits[15:8] == 8'h00;
            2'd1:    return digits[15:4] == 12'h000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the counter datapath / board pins and seg7_scan_ctrl.
// BLINK_MASK exists only when SCAN_BLINK_EN is defined.
interface seg7_scan_ctrl_if;
    logic        EN;
    logic [15:0] DIGITS;
    logic [3:0]  DP_IN;
    logic        BLANK_LZ;
`ifdef SCAN_BLINK_EN
    logic [3:0]  BLINK_MASK;
`endif
    logic [7:0]  LED;
    logic [3:0]  SA;
    logic        FRAME_TICK;

`ifdef SCAN_BLINK_EN
    modport master (output EN, DIGITS, DP_IN, BLANK_LZ, BLINK_MASK,
                    input  LED, SA, FRAME_TICK);
    modport slave  (input  EN, DIGITS, DP_IN, BLANK_LZ, BLINK_MASK,
                    output LED, SA, FRAME_TICK);
`else
    modport master (output EN, DIGITS, DP_IN, BLANK_LZ,
                    input  LED, SA, FRAME_TICK);
    modport slave  (input  EN, DIGITS, DP_IN, BLANK_LZ,
                    output LED, SA, FRAME_TICK);
`endif
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to {A..G} glyph; codes 10-15 render as a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans 4 snapshotted BCD digits onto one shared segment bus with a blank gap per slot.
// Optional digit blinking is built when SCAN_BLINK_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 5000,
    parameter int unsigned BLANK_CYC    = 50
`ifdef SCAN_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST       = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYC - 1);

    logic [1:0]    r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]   r_snap;
    logic [3:0]    r_dp;
    logic          w_snap_load;
    logic          w_frame_end;
    logic [7:0]    r_led, w_led_nxt;
    logic [3:0]    r_sa, w_sa_nxt;
    logic          r_tick, w_tick_nxt;
    logic [3:0]    w_code;
    logic [6:0]    w_glyph;
    logic          w_lz;
    logic          w_dark;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_snap_load = 1'b0;
        w_frame_end = 1'b0;
        if (!bus.EN) begin
            w_state_nxt = ST_OFF;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_BLANK;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                    w_snap_load = 1'b1;
                end
                ST_BLANK: begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CNT_BLANK_LAST)
                        w_state_nxt = ST_SHOW;
                end
                ST_SHOW: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + 2'd1;
                        // Wrapping back to digit0 starts a new frame with a fresh snapshot
                        if (r_idx == 2'd3) begin
                            w_snap_load = 1'b1;
                            w_frame_end = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] r_frames;
    logic          r_phase_on;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frames   <= '0;
            r_phase_on <= 1'b1;
        end else if (w_frame_end) begin
            if (r_frames == FW'(BLINK_FRAMES - 1)) begin
                r_frames   <= '0;
                r_phase_on <= ~r_phase_on;
            end else begin
                r_frames <= r_frames + FW'(1);
            end
        end
    end

    // Phase only flips on a frame wrap (entry to BLANK), so SHOW cycles see a settled value
    assign w_dark = !r_phase_on && bus.BLINK_MASK[w_idx_nxt];
`else
    assign w_dark = 1'b0;
`endif

    // Snapshot is stable whenever the next state is SHOW, so it feeds the decoder directly
    assign w_code = r_snap[{w_idx_nxt, 2'b00} +: 4];
    assign w_lz   = bus.BLANK_LZ && lz_blank(r_snap, w_idx_nxt);

    seg7_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    always_comb begin
        w_led_nxt  = '0;
        w_sa_nxt   = '0;
        w_tick_nxt = 1'b0;
        if (w_state_nxt == ST_SHOW) begin
            w_sa_nxt                       = 4'b0001 << w_idx_nxt;
            w_led_nxt[SEG_A_BIT:SEG_G_BIT] = w_lz ? SEG_OFF : w_glyph;
            w_led_nxt[SEG_DP_BIT]          = r_dp[w_idx_nxt];
            if (w_dark)
                w_led_nxt = '0;
            w_tick_nxt = (w_idx_nxt == 2'd3) && (w_cnt_nxt == CNT_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_OFF;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_snap  <= '0;
            r_dp    <= '0;
            r_led   <= '0;
            r_sa    <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_snap_load) begin
                r_snap <= bus.DIGITS;
                r_dp   <= bus.DP_IN;
            end
            r_led   <= w_led_nxt;
            r_sa    <= w_sa_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign bus.LED        = r_led;
    assign bus.SA         = r_sa;
    assign bus.FRAME_TICK = r_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random traffic
// against a position-in-frame reference model.
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
`ifdef SCAN_BLINK_EN
        ,
        .BLINK_FRAMES (BF)
`endif
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time since enable and completed frame count
    bit          m_on = 1'b0;
    int          pos = 0;
    int          frames = 0;
    logic [15:0] m_snap = '0;
    logic [3:0]  m_dp = '0;
    logic [7:0]  gly [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};

    task automatic step(input string tag);
        logic [7:0]  exp_led;
        logic [3:0]  exp_sa;
        logic        exp_tick;
        logic [15:0] upper;
        logic [7:0]  g;
        int          w, slot;
        bit          lz;
        @(posedge CLK);
        if (RESET) begin
            m_on   = 1'b0;
            frames = 0;
        end else if (!bus.EN) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on   = 1'b1;
            pos    = 0;
            m_snap = bus.DIGITS;
            m_dp   = bus.DP_IN;
        end else begin
            pos++;
            if (pos % FRAME == 0) begin
                frames++;
                m_snap = bus.DIGITS;
                m_dp   = bus.DP_IN;
            end
        end
        exp_led  = 8'h00;
        exp_sa   = 4'h0;
        exp_tick = 1'b0;
        if (m_on) begin
            w        = pos % SD;
            slot     = (pos / SD) % 4;
            exp_tick = (slot == 3) && (w == SD - 1);
            if (w >= BC) begin
                exp_sa  = 4'(1 << slot);
                upper   = m_snap >> (4 * slot);
                lz      = bus.BLANK_LZ && (slot > 0) && (upper == 16'h0);
                g       = gly[upper[3:0]];
                exp_led = {lz ? 7'b0 : g[7:1], m_dp[slot]};
`ifdef SCAN_BLINK_EN
                if (((frames / BF) % 2 == 1) && bus.BLINK_MASK[slot])
                    exp_led = 8'h00;
`endif
            end
        end
        #1;
        checks++;
        assert (bus.LED === exp_led) else begin
            errors++;
            $error("FAIL %s LED got %h exp %h (pos %0d)", tag, bus.LED, exp_led, pos);
        end
        checks++;
        assert (bus.SA === exp_sa) else begin
            errors++;
            $error("FAIL %s SA got %b exp %b (pos %0d)", tag, bus.SA, exp_sa, pos);
        end
        checks++;
        assert (bus.FRAME_TICK === exp_tick) else begin
            errors++;
            $error("FAIL %s FRAME_TICK got %b exp %b (pos %0d)", tag, bus.FRAME_TICK, exp_tick, pos);
        end
    endtask

    initial begin
        RESET        = 1'b1;
        bus.EN       = 1'b0;
        bus.DIGITS   = 16'h0000;
        bus.DP_IN    = 4'h0;
        bus.BLANK_LZ = 1'b0;
`ifdef SCAN_BLINK_EN
        bus.BLINK_MASK = 4'h0;
`endif
        repeat (2) step("reset");

        RESET      = 1'b0;
        bus.EN     = 1'b1;
        bus.DIGITS = 16'h1234;
        repeat (SD + BC + 1) step("frame1234");

        // now inside the digit1 SHOW window
        bus.DIGITS = 16'h5678;
        repeat (2 * FRAME - (SD + BC + 1)) step("midframe5678");

        bus.BLANK_LZ = 1'b1;
        bus.DIGITS   = 16'h0105;
        repeat (2 * FRAME) step("lz0105");

        bus.BLANK_LZ = 1'b0;
        bus.DIGITS   = 16'h00A0;
        bus.DP_IN    = 4'b0010;
        repeat (2 * FRAME) step("dashdp");

        for (int k = 0; k < FRAME + 2 && (pos % FRAME) != 2 * SD + BC + 2; k++)
            step("align");
        bus.EN = 1'b0;
        step("en_off");
        repeat (3) step("dark");
        bus.EN = 1'b1;
        repeat (SD + 4) step("reenable");
        RESET = 1'b1;
        step("midreset");
        RESET = 1'b0;
        repeat (4) step("postreset");

        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 15) == 0)
                for (int n = 0; n < 4; n++)
                    bus.DIGITS[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.DP_IN = 4'($urandom);
            if ($urandom_range(0, 63) == 0) bus.BLANK_LZ = ~bus.BLANK_LZ;
`ifdef SCAN_BLINK_EN
            if ($urandom_range(0, 63) == 0) bus.BLINK_MASK = 4'($urandom);
`endif
            bus.EN = ($urandom_range(0, 149) != 0);
            RESET  = ($urandom_range(0, 299) == 0);
            step("random");
        end
        RESET = 1'b0;
        bus.EN = 1'b1;

`ifdef SCAN_BLINK_EN
        RESET = 1'b1;
        step("blink_reset");
        RESET          = 1'b0;
        bus.DIGITS     = 16'h1234;
        bus.DP_IN      = 4'h0;
        bus.BLANK_LZ   = 1'b0;
        bus.BLINK_MASK = 4'b0001;
        repeat (4 * FRAME + 2) step("blink");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
